vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Generates 640x480@60Hz VGA raster timing from the 100 MHz system clock.
//   Produces pixel-rate enable, h_cnt/v_cnt, valid, hsync/vsync, and frame/vblank event pulses.
//   Feeds the display controller's pixel lookup and the game FSM's frame-synchronous updates.
//   The display controller is the counters' consumer.
// PARAMETERS
//   CLK_DIV    4    system clocks per pixel (100 MHz -> 25 MHz); >=2
//   H_DISPLAY  640  visible pixels per line
//   H_FP       16   horizontal front porch, pixels
//   H_SYNC     96   hsync pulse width, pixels
//   H_BP       48   horizontal back porch, pixels
//   V_DISPLAY  480  visible lines per frame
//   V_FP       10   vertical front porch, lines
//   V_SYNC     2    vsync pulse width, lines
//   V_BP       33   vertical back porch, lines
//   SYNC_POL   0    active level of hsync/vsync (0 = active-low)
// PORTS
//   clk          in   1   system clock, 100 MHz
//   rst          in   1   synchronous, active-high reset
//   enable       in   1   run raster; low = hold idle
//   pclk_en      out  1   1-clk strobe, once every CLK_DIV clks; counters advance on it
//   h_cnt        out  10  horizontal pixel index, 0..H_TOTAL-1
//   v_cnt        out  10  vertical line index, 0..V_TOTAL-1
//   valid        out  1   (h_cnt,v_cnt) inside visible area
//   hsync        out  1   horizontal sync, level per SYNC_POL
//   vsync        out  1   vertical sync, level per SYNC_POL
//   frame_start  out  1   1-clk pulse when counters wrap to (0,0)
//   vblank_start out  1   1-clk pulse when v_cnt becomes V_DISPLAY (h_cnt=0)
//   frame_count  out  16  frames completed since reset, wraps mod 2^16
// BEHAVIOUR
//   Totals: H_TOTAL=H_DISPLAY+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_DISPLAY+V_FP+V_SYNC+V_BP (525).
//   Reset and idle state:
//   - rst high: div=0, h_cnt=0, v_cnt=0, pclk_en=0, valid=0, frame_start=0, vblank_start=0, frame_count=0.
//   - rst high: hsync=vsync=~SYNC_POL (inactive).
//   - rst overrides enable.
//   - enable low (rst low): identical to reset, except frame_count holds its value.
//   - Raising enable restarts the raster at (0,0) with a fresh divider phase.
//   Divider and counters:
//   - div counts 0..CLK_DIV-1 and wraps.
//   - pclk_en is registered: high on the clk after div==CLK_DIV-1, so exactly 1 clk in CLK_DIV.
//   - On a pclk_en clk, h_cnt increments.
//   - h_cnt==H_TOTAL-1 -> h_cnt=0 and v_cnt increments.
//   - v_cnt==V_TOTAL-1 at that wrap -> v_cnt=0.
//   Decoded outputs:
//   - valid, hsync, vsync are registered from the NEXT counter values, so they change on the
//     same edge as h_cnt/v_cnt and are always consistent with them (zero relative latency).
//   - valid = h<H_DISPLAY && v<V_DISPLAY.
//   - First non-reset edge: valid=1 with counters at (0,0).
//   - hsync active iff H_DISPLAY+H_FP <= h < H_DISPLAY+H_FP+H_SYNC (656..751).
//   - vsync active iff V_DISPLAY+V_FP <= v < V_DISPLAY+V_FP+V_SYNC (490..491), for whole lines.
//   Event pulses:
//   - frame_start: high for exactly the clk on which counters go (799,524)->(0,0).
//   - frame_start: no pulse on reset/enable release.
//   - frame_count increments on that same edge; frame_count is visible +1 together with the pulse.
//   - vblank_start: high for exactly the clk on which (639,479)... wait, (799,479)->(0,480).
//   - Pulses never overlap; each lasts one clk, not one pixel.
//   - Reset mid-frame: all outputs reach their reset values on the next edge.
//   - No partial sync pulse persists beyond that edge.
// TESTING
//   1) rst=1 for 3 clks, then rst=0, enable=1 -> h=v=0, valid=1, hsync=vsync=1.
//      pclk_en first high 4 clks later; h_cnt=1 on that edge.
//   2) Run 800 pixels -> h_cnt 799->0 and v_cnt 0->1 on the same clk.
//      hsync low for exactly 96 pixels, starting at h_cnt=656.
//   3) Run full frame (800*525*4 = 1,680,000 clks) -> frame_start single 1-clk pulse at (0,0).
//      frame_count 0->1; vsync low for exactly 1600 pixel times starting at v_cnt=490.
//   4) Check vblank_start pulses once per frame at v_cnt=480,h_cnt=0.
//      valid low for all of lines 480..524 and columns 640..799.
//   5) Drop enable at h=300,v=200 for 10 clks -> idle values with frame_count held.
//      Re-raise enable -> restart at (0,0), no frame_start pulse.
//   6) Assert rst at (655,489) -> next edge h=v=0, hsync/vsync inactive, frame_count=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator. It defaults to 640x480@60Hz from a 100 MHz clock.
//   A clock divider produces the pixel-rate strobe. Horizontal and vertical
//   counters advance on that strobe. The visible-area, sync and event outputs
//   are decoded from the counters.
//
// Ports
//   i_clk            system clock
//   i_rst            synchronous, active-high reset (overrides i_enable)
//   i_enable         run raster; low holds idle (frame count is kept)
//   o_pclk_en        1-clk strobe, once every CLK_DIV clks
//   o_h_cnt          horizontal pixel index, 0..H_TOTAL-1
//   o_v_cnt          vertical line index, 0..V_TOTAL-1
//   o_valid          counters inside the visible area
//   o_hsync/o_vsync  sync outputs, active level SYNC_POL
//   o_frame_start    1-clk pulse when counters wrap to (0,0)
//   o_vblank_start   1-clk pulse when v_cnt becomes V_DISPLAY
//   o_frame_count    frames completed since reset, wraps mod 2^16
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int SYNC_POL  = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  output logic        o_pclk_en,
  output logic [9:0]  o_h_cnt,
  output logic [9:0]  o_v_cnt,
  output logic        o_valid,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_frame_start,
  output logic        o_vblank_start,
  output logic [15:0] o_frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FP + V_SYNC);
  localparam logic       SYNC_ON = (SYNC_POL != 0);

  logic [DIV_W-1:0] r_div;
  logic             r_pclk_en;
  logic [9:0]       r_h_cnt;
  logic [9:0]       r_v_cnt;
  logic             r_valid;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_frame_start;
  logic             r_vblank_start;
  logic [15:0]      r_frame_count;

  logic       w_tick;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic       w_vblank_hit;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;

  // The next counter values are computed here. The decoded outputs are
  // registered from them, so valid/sync switch on the same edge as the
  // counters.
  always_comb begin
    w_tick       = (r_div == DIV_LAST);
    w_h_wrap     = w_tick && (r_h_cnt == H_LAST);
    w_v_wrap     = w_h_wrap && (r_v_cnt == V_LAST);
    w_vblank_hit = w_h_wrap && (r_v_cnt == V_VIS - 10'd1);
    w_h_next     = r_h_cnt;
    w_v_next     = r_v_cnt;
    if (w_tick) begin
      w_h_next = w_h_wrap ? '0 : r_h_cnt + 10'd1;
    end
    if (w_h_wrap) begin
      w_v_next = w_v_wrap ? '0 : r_v_cnt + 10'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      r_div          <= '0;
      r_pclk_en      <= 1'b0;
      r_h_cnt        <= '0;
      r_v_cnt        <= '0;
      r_valid        <= 1'b0;
      r_hsync        <= ~SYNC_ON;
      r_vsync        <= ~SYNC_ON;
      r_frame_start  <= 1'b0;
      r_vblank_start <= 1'b0;
      if (i_rst) begin
        r_frame_count <= '0;
      end
    end else begin
      r_div          <= w_tick ? '0 : r_div + DIV_ONE;
      r_pclk_en      <= w_tick;
      r_h_cnt        <= w_h_next;
      r_v_cnt        <= w_v_next;
      r_valid        <= (w_h_next < H_VIS) && (w_v_next < V_VIS);
      r_hsync        <= ((w_h_next >= HS_BEG) && (w_h_next < HS_END)) ? SYNC_ON : ~SYNC_ON;
      r_vsync        <= ((w_v_next >= VS_BEG) && (w_v_next < VS_END)) ? SYNC_ON : ~SYNC_ON;
      r_frame_start  <= w_v_wrap;
      r_vblank_start <= w_vblank_hit;
      if (w_v_wrap) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign o_pclk_en      = r_pclk_en;
  assign o_h_cnt        = r_h_cnt;
  assign o_v_cnt        = r_v_cnt;
  assign o_valid        = r_valid;
  assign o_hsync        = r_hsync;
  assign o_vsync        = r_vsync;
  assign o_frame_start  = r_frame_start;
  assign o_vblank_start = r_vblank_start;
  assign o_frame_count  = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen, run with a reduced raster so that whole frames are short.
module tb_vga_timing_gen;

  localparam int CD  = 4;
  localparam int HD  = 16;
  localparam int HFP = 2;
  localparam int HS  = 4;
  localparam int HBP = 3;
  localparam int VD  = 10;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam logic POL = 1'b0;
  localparam int HT  = HD + HFP + HS + HBP;
  localparam int VT  = VD + VFP + VS + VBP;
  localparam int FT  = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        o_pclk_en;
  logic [9:0]  o_h_cnt;
  logic [9:0]  o_v_cnt;
  logic        o_valid;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_frame_start;
  logic        o_vblank_start;
  logic [15:0] o_frame_count;

  vga_timing_gen #(
    .CLK_DIV(CD), .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en),
    .o_pclk_en(o_pclk_en), .o_h_cnt(o_h_cnt), .o_v_cnt(o_v_cnt),
    .o_valid(o_valid), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_frame_start(o_frame_start), .o_vblank_start(o_vblank_start),
    .o_frame_count(o_frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pe;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        val;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        vb;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];
  int tests_run = 0;
  int tests_failed = 0;

  // Linear reference model: after enable, edge e shows pixel index (e+1)/CD.
  bit m_active = 1'b0;
  int m_e = 0;
  int m_base = 0;
  int m_fc = 0;

  task automatic drive(input logic r, input logic e);
    exp_t x;
    int p, h, v;
    @(negedge clk);
    rst = r;
    en  = e;
    x = '0;
    x.hs = ~POL;
    x.vs = ~POL;
    if (r) begin
      m_active = 1'b0;
      m_fc = 0;
    end else if (!e) begin
      m_active = 1'b0;
    end else begin
      if (!m_active) begin
        m_active = 1'b1;
        m_e = 0;
        m_base = m_fc;
      end else begin
        m_e++;
      end
      p = (m_e + 1) / CD;
      h = p % HT;
      v = (p / HT) % VT;
      x.pe  = ((m_e + 1) % CD == 0);
      x.h   = 10'(h);
      x.v   = 10'(v);
      x.val = (h < HD) && (v < VD);
      x.hs  = (h >= HD + HFP && h < HD + HFP + HS) ? POL : ~POL;
      x.vs  = (v >= VD + VFP && v < VD + VFP + VS) ? POL : ~POL;
      x.fs  = x.pe && (p % FT == 0);
      x.vb  = x.pe && (h == 0) && (v == VD);
      m_fc  = (m_base + p / FT) % 65536;
    end
    x.fc = 16'(m_fc);
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    exp_t a, x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      a = {o_pclk_en, o_h_cnt, o_v_cnt, o_valid, o_hsync, o_vsync,
           o_frame_start, o_vblank_start, o_frame_count};
      tests_run++;
      if (a !== x) begin
        tests_failed++;
        $display("FAIL scoreboard t=%0t pe/h/v/val/hs/vs/fs/vb/fc got %b/%0d/%0d/%b/%b/%b/%b/%b/%0d expected %b/%0d/%0d/%b/%b/%b/%b/%b/%0d",
                 $time, a.pe, a.h, a.v, a.val, a.hs, a.vs, a.fs, a.vb, a.fc,
                 x.pe, x.h, x.v, x.val, x.hs, x.vs, x.fs, x.vb, x.fc);
      end
    end
  end

  task automatic run_to(input int th, input int tv, input int limit, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < limit) begin
      drive(1'b0, 1'b1);
      n++;
      if (o_pclk_en && o_h_cnt == 10'(th) && o_v_cnt == 10'(tv)) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    int n;
    repeat (3) drive(1'b1, 1'b0);
    tests_run++;
    if ({o_h_cnt, o_v_cnt, o_valid, o_hsync, o_vsync, o_pclk_en, o_frame_start, o_vblank_start, o_frame_count}
        !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      tests_failed++;
      $display("FAIL reset_state got h=%0d v=%0d val=%b hs=%b vs=%b pe=%b fc=%0d expected 0/0/0/1/1/0/0",
               o_h_cnt, o_v_cnt, o_valid, o_hsync, o_vsync, o_pclk_en, o_frame_count);
    end
    drive(1'b0, 1'b1);
    tests_run++;
    if ({o_h_cnt, o_v_cnt, o_valid, o_hsync, o_vsync, o_pclk_en, o_frame_start}
        !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL first_edge got h=%0d v=%0d val=%b hs=%b vs=%b pe=%b fs=%b expected 0/0/1/1/1/0/0",
               o_h_cnt, o_v_cnt, o_valid, o_hsync, o_vsync, o_pclk_en, o_frame_start);
    end
    n = 1;
    while (!o_pclk_en && n < 20) begin
      drive(1'b0, 1'b1);
      n++;
    end
    tests_run++;
    if (n != CD) begin
      tests_failed++;
      $display("FAIL pclk_latency got %0d clks expected %0d", n, CD);
    end
    tests_run++;
    if (o_h_cnt !== 10'd1) begin
      tests_failed++;
      $display("FAIL first_pixel_h got %0d expected 1", o_h_cnt);
    end
  endtask

  task automatic test_line_wrap;
    int guard, hs_cnt, hs_first, hs_last, prev_h;
    bit done;
    guard = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; prev_h = -1; done = 1'b0;
    while (!done && guard < HT * CD * 2) begin
      drive(1'b0, 1'b1);
      guard++;
      if (o_pclk_en) begin
        if (o_v_cnt == 10'd1) begin
          done = 1'b1;
        end else begin
          if (o_hsync === POL) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(o_h_cnt);
            hs_last = int'(o_h_cnt);
          end
          prev_h = int'(o_h_cnt);
        end
      end
    end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL line_wrap_timeout got no v_cnt=1 within %0d clks expected wrap", guard);
    end
    tests_run++;
    if (o_h_cnt !== 10'd0 || prev_h != HT - 1) begin
      tests_failed++;
      $display("FAIL line_wrap got h=%0d prev_h=%0d expected 0 and %0d", o_h_cnt, prev_h, HT - 1);
    end
    tests_run++;
    if (hs_cnt != HS || hs_first != HD + HFP || hs_last != HD + HFP + HS - 1) begin
      tests_failed++;
      $display("FAIL hsync_window got cnt=%0d first=%0d last=%0d expected %0d/%0d/%0d",
               hs_cnt, hs_first, hs_last, HS, HD + HFP, HD + HFP + HS - 1);
    end
  endtask

  task automatic test_frame;
    int guard, vs_cnt, vs_first_v, vs_first_h, vb_cnt, vb_h, vb_v, val_bad;
    bit done;
    guard = 0; vs_cnt = 0; vs_first_v = -1; vs_first_h = -1;
    vb_cnt = 0; vb_h = -1; vb_v = -1; val_bad = 0; done = 1'b0;
    while (!done && guard < FT * CD + 50) begin
      drive(1'b0, 1'b1);
      guard++;
      if (o_frame_start) begin
        done = 1'b1;
      end else begin
        if (o_vblank_start) begin
          vb_cnt++;
          vb_h = int'(o_h_cnt);
          vb_v = int'(o_v_cnt);
        end
        if (o_valid !== ((o_h_cnt < 10'(HD)) && (o_v_cnt < 10'(VD)))) val_bad++;
        if (o_pclk_en && o_vsync === POL) begin
          vs_cnt++;
          if (vs_first_v < 0) begin
            vs_first_v = int'(o_v_cnt);
            vs_first_h = int'(o_h_cnt);
          end
        end
      end
    end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL frame_timeout got no frame_start within %0d clks expected one", guard);
    end
    tests_run++;
    if ({o_h_cnt, o_v_cnt, o_pclk_en, o_frame_count} !== {10'd0, 10'd0, 1'b1, 16'd1}) begin
      tests_failed++;
      $display("FAIL frame_start_pos got h=%0d v=%0d pe=%b fc=%0d expected 0/0/1/1",
               o_h_cnt, o_v_cnt, o_pclk_en, o_frame_count);
    end
    tests_run++;
    if (vs_cnt != VS * HT || vs_first_v != VD + VFP || vs_first_h != 0) begin
      tests_failed++;
      $display("FAIL vsync_window got cnt=%0d first=(%0d,%0d) expected %0d at (0,%0d)",
               vs_cnt, vs_first_h, vs_first_v, VS * HT, VD + VFP);
    end
    tests_run++;
    if (vb_cnt != 1 || vb_h != 0 || vb_v != VD) begin
      tests_failed++;
      $display("FAIL vblank_start got cnt=%0d at (%0d,%0d) expected 1 at (0,%0d)", vb_cnt, vb_h, vb_v, VD);
    end
    tests_run++;
    if (val_bad != 0) begin
      tests_failed++;
      $display("FAIL valid_window got %0d bad clks expected 0", val_bad);
    end
    drive(1'b0, 1'b1);
    tests_run++;
    if (o_frame_start !== 1'b0 || o_frame_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL frame_start_width got fs=%b fc=%0d expected 0/1", o_frame_start, o_frame_count);
    end
  endtask

  task automatic test_enable_drop;
    bit ok;
    run_to(12, 6, FT * CD + 50, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL enable_drop_reach got no (12,6) expected reached");
    end
    repeat (10) drive(1'b0, 1'b0);
    tests_run++;
    if ({o_h_cnt, o_v_cnt, o_valid, o_hsync, o_vsync, o_pclk_en, o_frame_start, o_vblank_start, o_frame_count}
        !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1}) begin
      tests_failed++;
      $display("FAIL idle_state got h=%0d v=%0d val=%b hs=%b vs=%b pe=%b fc=%0d expected 0/0/0/1/1/0/1",
               o_h_cnt, o_v_cnt, o_valid, o_hsync, o_vsync, o_pclk_en, o_frame_count);
    end
    drive(1'b0, 1'b1);
    tests_run++;
    if ({o_h_cnt, o_v_cnt, o_valid, o_frame_start, o_frame_count} !== {10'd0, 10'd0, 1'b1, 1'b0, 16'd1}) begin
      tests_failed++;
      $display("FAIL enable_restart got h=%0d v=%0d val=%b fs=%b fc=%0d expected 0/0/1/0/1",
               o_h_cnt, o_v_cnt, o_valid, o_frame_start, o_frame_count);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    run_to(HD + HFP + 1, VD + VFP, FT * CD + 50, ok);
    tests_run++;
    if (!ok || o_hsync !== POL || o_vsync !== POL) begin
      tests_failed++;
      $display("FAIL in_sync got ok=%b hs=%b vs=%b expected 1/%b/%b", ok, o_hsync, o_vsync, POL, POL);
    end
    drive(1'b1, 1'b1);
    tests_run++;
    if ({o_h_cnt, o_v_cnt, o_hsync, o_vsync, o_valid, o_frame_count}
        !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 16'd0}) begin
      tests_failed++;
      $display("FAIL reset_in_sync got h=%0d v=%0d hs=%b vs=%b val=%b fc=%0d expected 0/0/1/1/0/0",
               o_h_cnt, o_v_cnt, o_hsync, o_vsync, o_valid, o_frame_count);
    end
    run_to(HD + HFP - 1, VD + VFP - 1, FT * CD + 50, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL reset_mid_reach got no (%0d,%0d) expected reached", HD + HFP - 1, VD + VFP - 1);
    end
    drive(1'b1, 1'b1);
    tests_run++;
    if ({o_h_cnt, o_v_cnt, o_hsync, o_vsync, o_pclk_en, o_frame_count}
        !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 16'd0}) begin
      tests_failed++;
      $display("FAIL reset_mid got h=%0d v=%0d hs=%b vs=%b pe=%b fc=%0d expected 0/0/1/1/0/0",
               o_h_cnt, o_v_cnt, o_hsync, o_vsync, o_pclk_en, o_frame_count);
    end
    drive(1'b0, 1'b1);
    tests_run++;
    if (o_frame_start !== 1'b0 || o_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_no_pulse got fs=%b val=%b expected 0/1", o_frame_start, o_valid);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish by %0t expected completion", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_line_wrap();
    test_frame();
    test_enable_drop();
    test_reset_mid();
    @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
